ddr_tx_serializer: RTL

- Transmit gearbox that sits directly upstream of the DDR output register model.
- Accepts wide parallel words over a valid/ready handshake and slices each word into RATIO consecutive clock beats of (high-phase, low-phase) lane pairs.
- Its ddr_h/ddr_l outputs connect straight to the DDR output register's datain_h/datain_l, with clk shared as that register's outclock.
- Drives an idle pattern when no data is pending and flags underruns.

---
 rtl/ddr_tx_serializer.sv | 105 ++++++++++
 1 files changed

// File: rtl/ddr_tx_serializer.sv
// Parallel-to-DDR transmit gearbox: slices each 2*WIDTH*RATIO word into RATIO (high, low) lane beats.
// Optional link-training pattern generator enabled by defining DDR_TX_SERIALIZER_TRAIN_EN.
module ddr_tx_serializer #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned RATIO    = 4,
    parameter bit          IDLE_VAL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*WIDTH*RATIO-1:0] in_data,
    input  logic                     in_valid,
`ifdef DDR_TX_SERIALIZER_TRAIN_EN
    input  logic                     train_req,
`endif
    output logic                     in_ready,
    output logic [WIDTH-1:0]         ddr_h,
    output logic [WIDTH-1:0]         ddr_l,
    output logic                     ddr_en,
    output logic                     ddr_sow,
    output logic                     underrun
);

    localparam int unsigned WordW = 2 * WIDTH * RATIO;
    localparam int unsigned BeatW = 2 * WIDTH;
    localparam int unsigned CntW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(RATIO - 1);

`ifdef DDR_TX_SERIALIZER_TRAIN_EN
    typedef enum logic [1:0] {StIdle, StShift, StTrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q;
    logic [CntW-1:0]   beat_cnt_q;
    logic [WordW-1:0]  shreg_q;

    logic last_beat;
    logic at_boundary;
    logic train_go;
    logic xfer;

    assign last_beat   = (state_q == StShift) && (beat_cnt_q == LastBeat);
    // A new word (or training) may only start between words.
    assign at_boundary = (state_q == StIdle) || last_beat;

`ifdef DDR_TX_SERIALIZER_TRAIN_EN
    assign train_go = at_boundary && train_req;
`else
    assign train_go = 1'b0;
`endif

    assign in_ready = !rst && at_boundary && !train_go;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            shreg_q    <= '0;
            ddr_h      <= {WIDTH{IDLE_VAL}};
            ddr_l      <= {WIDTH{IDLE_VAL}};
            ddr_en     <= 1'b0;
            ddr_sow    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            ddr_sow  <= 1'b0;
            underrun <= 1'b0;
            if (xfer) begin
                // Beat 0 goes straight to the outputs; the shifter keeps the rest.
                state_q    <= StShift;
                beat_cnt_q <= '0;
                shreg_q    <= in_data >> BeatW;
                ddr_h      <= in_data[WIDTH-1:0];
                ddr_l      <= in_data[BeatW-1:WIDTH];
                ddr_en     <= 1'b1;
                ddr_sow    <= 1'b1;
`ifdef DDR_TX_SERIALIZER_TRAIN_EN
            end else if (train_go || (state_q == StTrain && train_req)) begin
                // High phase 1, low phase 0 gives a clock-like 1010 on the wire.
                state_q    <= StTrain;
                beat_cnt_q <= '0;
                ddr_h      <= '1;
                ddr_l      <= '0;
                ddr_en     <= 1'b0;
`endif
            end else if (state_q == StShift && !last_beat) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                shreg_q    <= shreg_q >> BeatW;
                ddr_h      <= shreg_q[WIDTH-1:0];
                ddr_l      <= shreg_q[BeatW-1:WIDTH];
                ddr_en     <= 1'b1;
            end else begin
                // Idle, end of a word with nothing queued, or leaving training.
                state_q    <= StIdle;
                beat_cnt_q <= '0;
                ddr_h      <= {WIDTH{IDLE_VAL}};
                ddr_l      <= {WIDTH{IDLE_VAL}};
                ddr_en     <= 1'b0;
                underrun   <= last_beat;
            end
        end
    end

endmodule
